// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status-flag controller for an 8 x 10-bit
// dual-port FIFO memory. It carries no data. It drives the memory addresses and
// enables, and it produces a read-valid strobe aligned with the memory's
// registered read data.
module fifo_ctrl #(
    parameter int MEM_LENGTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [CNT_WIDTH-1:0]  umbral_full,
    input  logic [CNT_WIDTH-1:0]  umbral_empty,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic                  valid_out,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  rd_vld_p1;
    logic                  err_q;

    // Advance a pointer by one slot, wrapping from the last entry back to 0.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == ADDR_WIDTH'(MEM_LENGTH - 1))
            return '0;
        else
            return p + ADDR_WIDTH'(1);
    endfunction

    // Flags decode from the registered count only. The enables therefore never
    // depend on the same-cycle decision of the other request.
    assign full         = (cnt == CNT_WIDTH'(MEM_LENGTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= umbral_full);
    assign almost_empty = (cnt <= umbral_empty);

    // Gating with reset_L keeps the memory quiet while reset is held.
    assign write_enable = push & ~full  & reset_L;
    assign read_enable  = pop  & ~empty & reset_L;

    assign write_addr = wr_ptr;
    assign read_addr  = rd_ptr;
    assign count      = cnt;
    assign valid_out  = rd_vld_p1;
    assign error      = err_q;

    // Occupancy next-state. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_next = cnt;
        case ({write_enable, read_enable})
            2'b10:   cnt_next = cnt + CNT_WIDTH'(1);
            2'b01:   cnt_next = cnt - CNT_WIDTH'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            wr_ptr <= '0;
        else if (write_enable)
            wr_ptr <= ptr_inc(wr_ptr);
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            rd_ptr <= '0;
        else if (read_enable)
            rd_ptr <= ptr_inc(rd_ptr);
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

    // Read-valid strobe: the memory registers read data at the edge that accepts
    // the pop, so the word is on the memory output one cycle later.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            rd_vld_p1 <= 1'b0;
        else
            rd_vld_p1 <= read_enable;
    end

    // Sticky error flag for a push while full or a pop while empty. It is
    // cleared only by reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            err_q <= 1'b0;
        else if ((push & full) | (pop & empty))
            err_q <= 1'b1;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl. It pairs the controller with a behavioural
// dual-port memory. Expectations come from constant tables and from a
// queue-based FIFO reference model.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push, pop;
    logic [3:0] umbral_full, umbral_empty;
    logic [3:0] write_addr, read_addr;
    logic       write_enable, read_enable, valid_out;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, error;

    logic [9:0] data_in;
    logic [9:0] data_out;
    logic [9:0] mem [8];

    int checks = 0;
    int errors = 0;

    // reference model state
    int         q[$];
    int         wcnt, rcnt;
    bit         m_err, m_vld;
    int         m_word;
    bit         cur_p, cur_r, cur_we, cur_re;
    logic [9:0] cur_d;

    fifo_ctrl #(.MEM_LENGTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
        .umbral_full(umbral_full), .umbral_empty(umbral_empty),
        .write_addr(write_addr), .read_addr(read_addr),
        .write_enable(write_enable), .read_enable(read_enable),
        .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    // behavioural dual-port memory with a registered read port
    always_ff @(posedge clk) begin
        if (write_enable) mem[write_addr[2:0]] <= data_in;
        if (read_enable)  data_out <= mem[read_addr[2:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        q.delete();
        wcnt = 0; rcnt = 0; m_err = 0; m_vld = 0; m_word = 0;
    endtask

    // Drive one cycle's requests, then compare every output with the model at the negedge.
    task automatic begin_cycle(input bit p, input bit r, input logic [9:0] d);
        int sz;
        push = p; pop = r; data_in = d;
        cur_p = p; cur_r = r; cur_d = d;
        @(negedge clk);
        sz = q.size();
        cur_we = p && (sz < 8);
        cur_re = r && (sz > 0);
        chk("m_write_enable", write_enable, cur_we);
        chk("m_read_enable",  read_enable,  cur_re);
        chk("m_count",        count,        sz);
        chk("m_full",         full,         sz == 8);
        chk("m_empty",        empty,        sz == 0);
        chk("m_almost_full",  almost_full,  sz >= int'(umbral_full));
        chk("m_almost_empty", almost_empty, sz <= int'(umbral_empty));
        chk("m_write_addr",   write_addr,   wcnt % 8);
        chk("m_read_addr",    read_addr,    rcnt % 8);
        chk("m_valid_out",    valid_out,    m_vld);
        chk("m_error",        error,        m_err);
        if (m_vld) chk("m_data_out", data_out, m_word);
    endtask

    // Let the clock edge happen, then advance the model.
    task automatic end_cycle();
        @(posedge clk);
        if (cur_re) begin m_word = q.pop_front(); rcnt++; end
        if (cur_we) begin q.push_back(int'(cur_d)); wcnt++; end
        if ((cur_p && !cur_we) || (cur_r && !cur_re)) m_err = 1;
        m_vld = cur_re;
        #1;
    endtask

    task automatic step(input bit p, input bit r, input logic [9:0] d);
        begin_cycle(p, r, d);
        end_cycle();
    endtask

    typedef struct {
        bit push; bit pop;
        bit we; bit re; int wa; int ra; int cnt;
        bit full; bit empty; bit af; bit err;
    } vec_t;

    function automatic vec_t mk(bit p, bit r, bit we, bit re, int wa, int ra, int c,
                                bit f, bit e, bit af, bit er);
        vec_t v;
        v.push = p; v.pop = r; v.we = we; v.re = re; v.wa = wa; v.ra = ra;
        v.cnt = c; v.full = f; v.empty = e; v.af = af; v.err = er;
        return v;
    endfunction

    initial begin
        vec_t tbl[18];
        logic [9:0] word_a;
        int bias;

        // Fill to full, overflow, drain, then underflow. umbral_full = 6.
        //             p  r  we re wa ra cnt f  e  af err
        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 0, 3, 0, 3, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, 4, 0, 4, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 5, 0, 5, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 0, 6, 0, 6, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 1, 0, 7, 0, 7, 0, 0, 1, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0);
        tbl[9]  = mk(0, 1, 0, 1, 0, 0, 8, 1, 0, 1, 1);
        tbl[10] = mk(0, 1, 0, 1, 0, 1, 7, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 0, 1, 0, 2, 6, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 0, 1, 0, 3, 5, 0, 0, 0, 1);
        tbl[13] = mk(0, 1, 0, 1, 0, 4, 4, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 0, 1, 0, 5, 3, 0, 0, 0, 1);
        tbl[15] = mk(0, 1, 0, 1, 0, 6, 2, 0, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 1, 0, 7, 1, 0, 0, 0, 1);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Reset held with both requests active.
        reset_L = 1'b0; push = 1'b1; pop = 1'b1; data_in = '0;
        umbral_full = 4'd6; umbral_empty = 4'd2;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_read_enable",  read_enable,  0);
        chk("rst_count",        count,        0);
        chk("rst_empty",        empty,        1);
        chk("rst_full",         full,         0);
        chk("rst_error",        error,        0);
        chk("rst_valid_out",    valid_out,    0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full6", almost_full,  0);
        umbral_full = 4'd0;
        #1 chk("rst_almost_full0", almost_full, 1);
        umbral_full = 4'd6;
        @(posedge clk); #1;
        reset_L = 1'b1; push = 1'b0; pop = 1'b0;
        #1;
        chk("rel_write_addr", write_addr, 0);
        chk("rel_read_addr",  read_addr,  0);

        // Table-driven fill, overflow, drain and underflow.
        for (int i = 0; i < 18; i++) begin
            begin_cycle(tbl[i].push, tbl[i].pop, 10'(i + 1));
            chk($sformatf("t%0d_we", i),    write_enable, tbl[i].we);
            chk($sformatf("t%0d_re", i),    read_enable,  tbl[i].re);
            chk($sformatf("t%0d_wa", i),    write_addr,   tbl[i].wa);
            chk($sformatf("t%0d_ra", i),    read_addr,    tbl[i].ra);
            chk($sformatf("t%0d_cnt", i),   count,        tbl[i].cnt);
            chk($sformatf("t%0d_full", i),  full,         tbl[i].full);
            chk($sformatf("t%0d_empty", i), empty,        tbl[i].empty);
            chk($sformatf("t%0d_af", i),    almost_full,  tbl[i].af);
            chk($sformatf("t%0d_err", i),   error,        tbl[i].err);
            if (i >= 10 && i <= 17)
                chk($sformatf("t%0d_data", i), data_out, i - 9);
            end_cycle();
        end

        // Simultaneous push and pop at count 3 for 10 cycles, crossing the wrap.
        for (int i = 0; i < 3; i++) step(1, 0, 10'h100 + 10'(i));
        for (int i = 0; i < 10; i++) step(1, 1, 10'h200 + 10'(i));
        chk("sim_count", count,      3);
        chk("sim_waddr", write_addr, 5);
        chk("sim_raddr", read_addr,  2);

        // Asynchronous reset mid-operation at count 5 with error set.
        for (int i = 0; i < 2; i++) step(1, 0, 10'h300 + 10'(i));
        step(1, 1, 10'h310);
        push = 1'b1; pop = 1'b1;
        #1;
        chk("pre_rst_count", count,     5);
        chk("pre_rst_valid", valid_out, 1);
        chk("pre_rst_error", error,     1);
        reset_L = 1'b0;
        #1;
        chk("arst_count",        count,        0);
        chk("arst_waddr",        write_addr,   0);
        chk("arst_raddr",        read_addr,    0);
        chk("arst_write_enable", write_enable, 0);
        chk("arst_read_enable",  read_enable,  0);
        chk("arst_valid",        valid_out,    0);
        chk("arst_error",        error,        0);
        chk("arst_empty",        empty,        1);
        chk("arst_full",         full,         0);
        @(posedge clk); #1;
        reset_L = 1'b1; push = 1'b0; pop = 1'b0;
        mreset();

        // Push and pop together when empty: only the push is accepted.
        word_a = 10'h2aa;
        step(1, 1, word_a);
        chk("edge_empty_count", count,      1);
        chk("edge_empty_error", error,      1);
        chk("edge_empty_waddr", write_addr, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 10'h040 + 10'(i));
        chk("edge_full_pre", count, 8);
        // Push and pop together when full: only the pop is accepted.
        step(1, 1, 10'h3ff);
        chk("edge_full_count", count,  7);
        chk("edge_full_error", error,  1);
        chk("edge_full_mem0",  mem[0], word_a);
        step(0, 0, 10'h0);

        // Randomized traffic against the reference model.
        reset_L = 1'b0;
        #1;
        @(posedge clk); #1;
        reset_L = 1'b1;
        mreset();
        for (int i = 0; i < 600; i++) begin
            case ((i / 100) % 3)
                0:       bias = 70;
                1:       bias = 30;
                default: bias = 50;
            endcase
            umbral_full  = 4'($urandom_range(0, 15));
            umbral_empty = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
                 10'($urandom_range(0, 1023)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the 8-entry × 10-bit FIFO storage array. It sits directly upstream of the dual-port memory and drives that memory's `write_addr`, `read_addr`, `write_enable` and `read_enable`. It accepts push/pop requests from the surrounding logic and reports full, empty, almost-full/almost-empty and an overflow/underflow error. Upstream data goes straight to the memory's `Fifo_Data_in`; this block carries no data, only control plus a read-valid strobe aligned with `Fifo_Data_out`.

## Interface
- `MEM_LENGTH`, 8, number of storage entries; the pointers wrap modulo this value.
- `ADDR_WIDTH`, 4, width of the address ports; the upper bits are 0 for depth 8.
- `CNT_WIDTH`, 4, width of the occupancy counter and threshold inputs; holds 0..MEM_LENGTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request; the data word is valid on `Fifo_Data_in` in the same cycle.
- `pop`  in  1  read request.
- `umbral_full`  in  CNT_WIDTH  almost-full threshold.
- `umbral_empty`  in  CNT_WIDTH  almost-empty threshold.
- `write_addr`  out  ADDR_WIDTH  memory write address (registered write pointer).
- `read_addr`  out  ADDR_WIDTH  memory read address (registered read pointer).
- `write_enable`  out  1  accepted push, to the memory.
- `read_enable`  out  1  accepted pop, to the memory.
- `valid_out`  out  1  high when `Fifo_Data_out` holds popped data.
- `count`  out  CNT_WIDTH  current occupancy.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `error`  out  1  sticky overflow/underflow indicator.

## Operation
- State is held in `wr_ptr` and `rd_ptr` (0..MEM_LENGTH-1), `count` (0..MEM_LENGTH), `valid_out` and `error`.
- Push acceptance: `write_enable = push & ~full & reset_L`.
- Pop acceptance: `read_enable = pop & ~empty & reset_L`.
- Both enables are combinational from the request inputs and the registered `full` and `empty`.
- On an accepted push, `wr_ptr` advances by 1 and wraps from MEM_LENGTH-1 to 0.
- On an accepted pop, `rd_ptr` advances by 1 with the same wrap.
- Count update:
  - push only: +1
  - pop only: -1
  - both accepted: unchanged
  - neither accepted: unchanged
- `full = (count == MEM_LENGTH)` and `empty = (count == 0)`. Both decode from registered `count` only.
- `almost_full = (count >= umbral_full)` and `almost_empty = (count <= umbral_empty)`. Both are unsigned compares and combinational from `count` and the thresholds.
- Simultaneous push and pop:
  - Neither full nor empty: both are accepted.
  - Empty: only the push is accepted. The pop is rejected and sets `error`.
  - Full: only the pop is accepted. The push is rejected and sets `error`.
  - When full, `wr_ptr == rd_ptr`, so rejecting the push avoids a same-address read and write.
- `error` is set by a push while full or a pop while empty. It stays high until reset.
- A rejected request never changes the pointers or `count`.

## Timing
- Reset values (forced immediately while `reset_L` is low):
  - `wr_ptr`, `rd_ptr`, `count`: 0
  - `write_addr`, `read_addr`: 0
  - `write_enable`, `read_enable`: 0
  - `valid_out`: 0
  - `error`: 0
  - `full`: 0, `empty`: 1
  - `almost_empty`: 1, because 0 <= any threshold
  - `almost_full`: 1 only if `umbral_full` == 0
- Reset mid-operation discards all contents. After `reset_L` rises, the first accepted push writes address 0.
- Write: `write_addr` and `write_enable` are valid in cycle N, and the memory captures the data at the rising edge ending cycle N. The pointer and `count` update at that same edge.
- Read: the pop is accepted in cycle N and the memory registers `Fifo_Data_out` at the edge ending cycle N. `valid_out` is high during cycle N+1 only, giving 1-cycle latency.
- Back-to-back pops give one valid word per cycle.
- A push into an empty FIFO in cycle N makes `empty` fall in N+1. The earliest pop is accepted in N+1 and its data is valid in N+2.

## Test plan
- Reset: hold `reset_L` = 0 while `push` = `pop` = 1 -> both enables 0, `count` = 0, `empty` = 1, `error` = 0; after release, `write_addr` = `read_addr` = 0.
- Fill and overflow: with `umbral_full` = 6, push 0x001..0x008 on 8 consecutive cycles -> `write_addr` 0..7, `almost_full` rises at `count` = 6, `full` = 1 at `count` = 8. A 9th push -> `write_enable` = 0, `count` stays 8, `error` = 1.
- Drain and underflow: pop 8 times from full -> `Fifo_Data_out` reads 0x001..0x008 in order, each with `valid_out` one cycle after `read_enable`, and `empty` = 1 at the end. A 9th pop -> `read_enable` = 0, `error` stays 1.
- Simultaneous: at `count` = 3, push and pop together for 10 cycles -> `count` stays 3 and both pointers advance 10 positions, passing through the wrap 7 -> 0.
- Edge simultaneity: push+pop when empty -> `count` becomes 1 and `error` = 1; push+pop when full -> `count` becomes 7, `error` = 1, and no write occurs.
- Reset mid-operation: pulse `reset_L` low at `count` = 5 with `error` = 1 -> everything returns to reset values asynchronously, before the next clock edge.
